// File: rtl/maxpool_2x2_stream_pkg.sv
// Shared types and helpers for the pooling / activation stages that sit
// downstream of the convolution windower.
package maxpool_2x2_stream_pkg;

  // Widest channel the shared compare helper handles; narrower channels
  // are sign-extended into it and truncated back afterwards.
  localparam int MAX_BW = 32;

  // Native channel width of the layer-1 output stream.
  localparam int PIX_BW = 16;

  // One signed channel value.
  typedef logic signed [PIX_BW-1:0] pix_t;

  // Row-parity state: even rows fill the line buffer, odd rows pool.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_POOL = 1'b1
  } pool_state_e;

  // Signed max of one channel pair. Ties return b; both operands are equal
  // then, so the choice is invisible.
  function automatic logic signed [MAX_BW-1:0] chan_max(
    input logic signed [MAX_BW-1:0] a,
    input logic signed [MAX_BW-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_2x2_stream_pool_linebuf.sv
// Half-row line buffer: holds the horizontal maxima of an even row until
// the matching odd row arrives. One write port, one combinational read port.
module pool_linebuf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 1024
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  // Contents need no reset: every entry is written in the even row before
  // the odd row reads it.
  logic [W-1:0] mem_q [DEPTH];

  // Write port, used only while filling an even row.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Combinational read so the pooled result is ready in the same cycle.
  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 / stride-2 signed max-pool. Takes one raster pixel per
// valid cycle and emits one pooled pixel per 2x2 block, one cycle after
// the block's bottom-right pixel is accepted.
//
// Handshake: vld_in qualifies in for exactly that cycle; there is no ready,
// the stage accepts every cycle. vld_out is a one-cycle pulse qualifying
// out, and the consumer must take it in that cycle.
module maxpool_2x2_stream #(
  parameter int IMG_SIZE = 32,
  parameter int CH       = 64,
  parameter int BW       = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   vld_in,
  input  logic [CH-1:0][BW-1:0]  in,
  output logic                   vld_out,
  output logic [CH-1:0][BW-1:0]  out,
  output logic                   dbg_state
);

  import maxpool_2x2_stream_pkg::*;

  localparam int CW    = (IMG_SIZE > 2) ? $clog2(IMG_SIZE) : 1;
  localparam int DEPTH = IMG_SIZE / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int W     = CH * BW;

  logic [CW-1:0]          col_q, col_d;
  logic [CW-1:0]          row_q, row_d;
  pool_state_e            state_q, state_d;
  logic [CH-1:0][BW-1:0]  hold_q, hold_d;
  logic [CH-1:0][BW-1:0]  out_q, out_d;
  logic                   vld_out_q, vld_out_d;

  logic [CH-1:0][BW-1:0]  hmax;
  logic [CH-1:0][BW-1:0]  pooled;
  logic [CH-1:0][BW-1:0]  lb_rd;
  logic [W-1:0]           lb_rd_flat;
  logic                   lb_wr_en;
  logic [AW-1:0]          lb_addr;
  logic                   col_last;
  logic                   row_last;

  assign col_last = (col_q == CW'(IMG_SIZE - 1));
  assign row_last = (row_q == CW'(IMG_SIZE - 1));

  // Both ports address the same half-row slot; they are never active
  // together because FILL writes and POOL reads.
  assign lb_addr = AW'(col_q >> 1);
  assign lb_rd   = lb_rd_flat;

  pool_linebuf #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (W)
  ) u_linebuf (
    .clock   (clock),
    .wr_en   (lb_wr_en),
    .wr_addr (lb_addr),
    .wr_data (hmax),
    .rd_addr (lb_addr),
    .rd_data (lb_rd_flat)
  );

  // Per-channel horizontal max of the held even-column pixel and the
  // current odd-column pixel, then vertical max against the stored row.
  always_comb begin
    hmax   = '0;
    pooled = '0;
    for (int i = 0; i < CH; i++) begin
      hmax[i]   = BW'(chan_max(MAX_BW'($signed(hold_q[i])), MAX_BW'($signed(in[i]))));
      pooled[i] = BW'(chan_max(MAX_BW'($signed(lb_rd[i])), MAX_BW'($signed(hmax[i]))));
    end
  end

  // Next-state: raster counters, row-parity FSM, hold, line-buffer write
  // and output capture. Nothing moves on a cycle without vld_in.
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    state_d   = state_q;
    hold_d    = hold_q;
    out_d     = out_q;
    vld_out_d = 1'b0;
    lb_wr_en  = 1'b0;
    if (vld_in) begin
      if (col_last) begin
        col_d   = '0;
        row_d   = row_last ? '0 : (row_q + CW'(1));
        state_d = (state_q == ST_FILL) ? ST_POOL : ST_FILL;
      end else begin
        col_d = col_q + CW'(1);
      end
      if (!col_q[0]) begin
        hold_d = in;
      end else if (state_q == ST_FILL) begin
        lb_wr_en = 1'b1;
      end else begin
        out_d     = pooled;
        vld_out_d = 1'b1;
      end
    end
  end

  // All control and datapath registers; asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_q     <= '0;
      row_q     <= '0;
      state_q   <= ST_FILL;
      hold_q    <= '0;
      out_q     <= '0;
      vld_out_q <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      out_q     <= out_d;
      vld_out_q <= vld_out_d;
    end
  end

  assign vld_out   = vld_out_q;
  assign out       = out_q;
  assign dbg_state = (state_q == ST_POOL);

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Bench for maxpool_2x2_stream: a small 4x4x2 instance for directed cases
// and a default-size instance for random whole images.
module tb_maxpool_2x2_stream;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic               vld_s, vld_out_s, dbg_s;
  logic [1:0][15:0]   in_s, out_s;
  logic               vld_l, vld_out_l, dbg_l;
  logic [63:0][15:0]  in_l, out_l;

  maxpool_2x2_stream #(.IMG_SIZE(4), .CH(2), .BW(16)) dut_s (
    .clock (clock), .reset (reset), .vld_in (vld_s), .in (in_s),
    .vld_out (vld_out_s), .out (out_s), .dbg_state (dbg_s)
  );

  maxpool_2x2_stream dut_l (
    .clock (clock), .reset (reset), .vld_in (vld_l), .in (in_l),
    .vld_out (vld_out_l), .out (out_l), .dbg_state (dbg_l)
  );

  // ---------------- scoreboard ----------------
  int compared   = 0;
  int mismatched = 0;

  logic [31:0]   exp_q[$];
  int            exp_cyc_q[$];
  int            pulses_s = 0;
  logic [1023:0] exp_l_q[$];
  int            exp_l_cyc_q[$];
  int            pulses_l = 0;

  logic [31:0]   img_s [4][4];
  logic [1023:0] img_l [32][32];

  logic          due_s, due_l;
  logic [31:0]   e_s;
  logic [1023:0] e_l;

  function automatic logic [15:0] smax(input logic [15:0] a, input logic [15:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // Small instance monitor: each pulse must land on its scheduled cycle
  // and carry the expected pooled value.
  always @(negedge clock) begin
    if (reset) begin
      due_s = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
      if (vld_out_s || due_s) begin
        compared++;
        assert (vld_out_s === due_s) else begin
          mismatched++;
          $error("FAIL small_vld_out cyc=%0d observed=%b expected=%b", cyc, vld_out_s, due_s);
        end
        if (vld_out_s) pulses_s++;
        if (due_s) begin
          e_s = exp_q.pop_front();
          void'(exp_cyc_q.pop_front());
          if (vld_out_s) begin
            compared++;
            assert (out_s === e_s) else begin
              mismatched++;
              $error("FAIL small_out cyc=%0d observed=%h expected=%h", cyc, out_s, e_s);
            end
          end
        end
      end
    end
  end

  // Large instance monitor, same rules.
  always @(negedge clock) begin
    if (reset) begin
      due_l = (exp_l_cyc_q.size() > 0) && (exp_l_cyc_q[0] == cyc);
      if (vld_out_l || due_l) begin
        compared++;
        assert (vld_out_l === due_l) else begin
          mismatched++;
          $error("FAIL large_vld_out cyc=%0d observed=%b expected=%b", cyc, vld_out_l, due_l);
        end
        if (vld_out_l) pulses_l++;
        if (due_l) begin
          e_l = exp_l_q.pop_front();
          void'(exp_l_cyc_q.pop_front());
          if (vld_out_l) begin
            compared++;
            assert (out_l === e_l) else begin
              mismatched++;
              for (int k = 0; k < 64; k++) begin
                if (out_l[k] !== e_l[k*16 +: 16]) begin
                  $error("FAIL large_out cyc=%0d ch=%0d observed=%h expected=%h",
                         cyc, k, out_l[k], e_l[k*16 +: 16]);
                  break;
                end
              end
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_s(input logic v, input logic [31:0] d);
    @(posedge clock);
    #1;
    vld_s = v;
    in_s  = d;
  endtask

  task automatic drive_l(input logic v, input logic [1023:0] d);
    @(posedge clock);
    #1;
    vld_l = v;
    in_l  = d;
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Build a 4x4 image: mode 0 = ch0 idx+off, ch1 -idx+off; mode 1 = signed
  // corner cases in the top two blocks.
  task automatic build_s(input int mode, input int off);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        img_s[r][c] = {16'(off - (r*4 + c)), 16'(off + r*4 + c)};
      end
    end
    if (mode == 1) begin
      img_s[0][0] = {16'h0000, 16'h8000};
      img_s[0][1] = {16'h0000, 16'hFFFF};
      img_s[1][0] = {16'h0000, 16'hFFFB};
      img_s[1][1] = {16'h0000, 16'h8001};
      img_s[0][2] = {16'h8000, 16'h7FFF};
      img_s[0][3] = {16'h7FFF, 16'h8000};
      img_s[1][2] = {16'h0000, 16'h0000};
      img_s[1][3] = {16'h0000, 16'h0000};
    end
  endtask

  // Drive the first npix pixels of img_s, optionally with a gap after each.
  task automatic run_s(input int npix, input bit gap);
    logic [15:0] m0, m1;
    for (int p = 0; p < npix; p++) begin
      int r, c;
      r = p / 4;
      c = p % 4;
      drive_s(1'b1, img_s[r][c]);
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        m0 = smax(smax(img_s[r-1][c-1][15:0], img_s[r-1][c][15:0]),
                  smax(img_s[r][c-1][15:0],   img_s[r][c][15:0]));
        m1 = smax(smax(img_s[r-1][c-1][31:16], img_s[r-1][c][31:16]),
                  smax(img_s[r][c-1][31:16],   img_s[r][c][31:16]));
        exp_q.push_back({m1, m0});
        exp_cyc_q.push_back(cyc + 1);
      end
      if (gap) drive_s(1'b0, $urandom);
    end
  endtask

  task automatic idle_s(input int n);
    for (int i = 0; i < n; i++) drive_s(1'b0, $urandom);
  endtask

  // One random 32x32x64 image on the large instance.
  task automatic run_l();
    logic [15:0] m;
    logic [1023:0] e;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        for (int k = 0; k < 64; k++)
          img_l[r][c][k*16 +: 16] = 16'($urandom);
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) begin
        drive_l(1'b1, img_l[r][c]);
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          for (int k = 0; k < 64; k++) begin
            m = smax(smax(img_l[r-1][c-1][k*16 +: 16], img_l[r-1][c][k*16 +: 16]),
                     smax(img_l[r][c-1][k*16 +: 16],   img_l[r][c][k*16 +: 16]));
            e[k*16 +: 16] = m;
          end
          exp_l_q.push_back(e);
          exp_l_cyc_q.push_back(cyc + 1);
        end
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0;
    vld_s = 1'b0;
    in_s  = '0;
    vld_l = 1'b0;
    in_l  = '0;
    repeat (3) @(posedge clock);
    #1;
    check_word("reset_vld_out_s", {31'b0, vld_out_s}, 32'd0);
    check_word("reset_out_s", out_s, 32'd0);
    check_word("reset_vld_out_l", {31'b0, vld_out_l}, 32'd0);
    compared++;
    assert (out_l === '0) else begin
      mismatched++;
      $error("FAIL reset_out_l observed_nonzero expected=0");
    end
    @(negedge clock);
    reset = 1'b1;

    // Continuous index image: outputs 5,7,13,15 / 0,-2,-8,-10.
    pulses_s = 0;
    build_s(0, 0);
    run_s(16, 1'b0);
    idle_s(3);
    check_int("basic_pulses", pulses_s, 4);
    check_int("basic_drain", exp_q.size(), 0);

    // Signed extremes.
    pulses_s = 0;
    build_s(1, 0);
    run_s(16, 1'b0);
    idle_s(3);
    check_int("signed_pulses", pulses_s, 4);
    check_int("signed_drain", exp_q.size(), 0);

    // Same index image with a gap after every pixel.
    pulses_s = 0;
    build_s(0, 0);
    run_s(16, 1'b1);
    idle_s(3);
    check_int("gap_pulses", pulses_s, 4);
    check_int("gap_drain", exp_q.size(), 0);

    // Two images back to back, second offset by 100.
    pulses_s = 0;
    build_s(0, 0);
    run_s(16, 1'b0);
    build_s(0, 100);
    run_s(16, 1'b0);
    idle_s(3);
    check_int("b2b_pulses", pulses_s, 8);
    check_int("b2b_drain", exp_q.size(), 0);

    // Reset after 9 pixels; vld_in held high during reset must be ignored.
    build_s(0, 0);
    run_s(9, 1'b0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_word("midreset_vld_out", {31'b0, vld_out_s}, 32'd0);
    check_word("midreset_out", out_s, 32'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    vld_s = 1'b1;
    in_s  = 32'h1234_5678;
    repeat (3) @(posedge clock);
    #1;
    check_word("inreset_vld_out", {31'b0, vld_out_s}, 32'd0);
    vld_s = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    pulses_s = 0;
    build_s(0, 7);
    run_s(16, 1'b0);
    idle_s(3);
    check_int("postreset_pulses", pulses_s, 4);
    check_int("postreset_drain", exp_q.size(), 0);

    // Default parameters, three random images back to back.
    pulses_l = 0;
    run_l();
    run_l();
    run_l();
    drive_l(1'b0, '0);
    repeat (3) @(posedge clock);
    #1;
    check_int("large_pulses", pulses_l, 768);
    check_int("large_drain", exp_l_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/maxpool_2x2_stream.md
Name: maxpool_2x2_stream

Overview:
- Streaming 2x2, stride-2 signed max-pool stage directly downstream of the conv_windower/lyr1 layer output.
- Consumes one CH-channel pixel per valid cycle in raster order and emits one pooled pixel per 2x2 block.
- Output is IMG_SIZE/2 x IMG_SIZE/2 pixels per image, for the next layer's windower.
- Holds one half-row of horizontal maxima in an internal line buffer.

Parameters:
- IMG_SIZE, 32, input image width = height; must be even, >= 2.
- CH, 64, channels per pixel (matches the upstream CH_OUT).
- BW, 16, bits per channel, signed two's complement.

Ports:
- clock  input  1  single clock, all logic rising-edge.
- reset  input  1  asynchronous assert, active-low (0 = reset); release synchronised externally.
- vld_in  input  1  qualifies in; one raster pixel per asserted cycle; gaps allowed.
- in  input  [CH-1:0][BW-1:0]  input pixel, channel-packed, signed per channel.
- vld_out  output  1  one-cycle pulse per pooled pixel.
- out  output  [CH-1:0][BW-1:0]  pooled pixel, valid when vld_out=1.

Behaviour:
- Reset (reset=0, asynchronous): col=0, row=0, vld_out=0, out=0, hold register=0. Line buffer contents are don't-care; they are never read before being written.
- Counters:
  - col in 0..IMG_SIZE-1 and row in 0..IMG_SIZE-1 advance only on vld_in.
  - col wraps to 0 and row increments at col=IMG_SIZE-1.
  - At row=IMG_SIZE-1, col=IMG_SIZE-1, both wrap to 0. The next pixel starts a new image with no idle cycle required.
- Row-parity state machine:
  - FILL when row is even, POOL when row is odd.
  - FILL->POOL and POOL->FILL on the accepted last pixel of the row.
  - Reset state is FILL.
- Horizontal stage:
  - vld_in with col even: hold <= in.
  - vld_in with col odd: hmax = per-channel signed max(hold, in), combinational.
- FILL, col odd: linebuf[col>>1] <= hmax. No output.
- POOL, col odd: out <= per-channel signed max(linebuf[col>>1], hmax); vld_out <= 1 on the next edge.
- Latency: vld_out asserts exactly 1 cycle after the accepted odd-row, odd-column input. Otherwise vld_out=0.
- out holds its last value when vld_out=0.
- Arithmetic:
  - Comparison is signed BW-bit per channel.
  - Equal values select either operand (result identical).
  - No saturation or width growth; out width = in width.
- Throughput: accepts vld_in every cycle indefinitely. No backpressure port; the downstream stage must always accept.
- Line buffer: IMG_SIZE/2 entries x CH*BW bits. Single write port (FILL) and single read port (POOL), never the same cycle. Implemented as registers or distributed RAM with combinational read.
- Boundaries:
  - Gaps in vld_in freeze all state, including hold.
  - vld_in during reset is ignored.
  - Reset mid-image discards the partial image; the next accepted pixel is (row 0, col 0).
  - An image ending mid-stream is not supported; the upstream stage always supplies whole images.

Decomposition:
- Shared package: pixel typedef (logic signed [BW-1:0] per channel), plus a function for signed per-channel vector max reused by future pooling/ReLU stages.
- One natural sub-module: pool_linebuf (IMG_SIZE/2-deep, CH*BW-wide, one write and one read port, combinational read).
- Counters, FSM, hold register and output register live in maxpool_2x2_stream.

Test Plan:
- IMG_SIZE=4, CH=2, continuous vld_in, channel0 = raster index 0..15, channel1 = -index.
  - Exactly 4 vld_out pulses.
  - Channel0 = 5, 7, 13, 15; channel1 = 0, -2, -8, -10.
  - Each pulse 1 cycle after inputs 5, 7, 13, 15.
- Signed check: block values {-32768, -1, -5, -32767} -> out = -1; block {32767, -32768, 0, 0} -> 32767.
- Gapped input: same stimulus as the first test with vld_in toggling 1,0,1,0 -> identical out sequence. Each vld_out is 1 cycle after its completing valid input; no output during gaps.
- Back-to-back images: two 4x4 images, second = first + 100, no idle cycle -> 8 outputs; second four = first four + 100.
- Reset mid-image: assert reset after 9 pixels -> vld_out=0 and out=0 immediately (asynchronous). A fresh full image afterwards yields exactly 4 correct outputs.
- Default parameters (32, 64, 16), random signed data over 3 images -> matches reference-model max-pool on all 256 outputs per image; vld_out count = 768.
